// File: rtl/cherry_dcache_pkg.sv
// Shared types and geometry for the banked tile data cache.
package cherry_dcache_pkg;

  localparam int SZ        = 4;                  // tile rows per request (also elements per row)
  localparam int LOGCNT    = 5;                  // log2 bank count
  localparam int DEPTH_LOG = 10;                 // log2 words per bank
  localparam int BITS      = 18;                 // element width
  localparam int CNT       = 1 << LOGCNT;        // bank count
  localparam int AW        = DEPTH_LOG + LOGCNT; // row address width
  localparam int LINE      = BITS * SZ;          // one row of elements
  localparam int PW        = $clog2(SZ) + 1;     // pass counter width

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    ISSUE,
    DONE
  } state_t;

endpackage

// File: rtl/dcache_bank_ram.sv
// Single-port bank SRAM: registered read, write does not update the read port.
module dcache_bank_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 72
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // One access per enabled cycle: write the word, or register the read word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dcache_tile_banked.sv
// Banked tile-access data cache. A tile of SZ strided rows is spread over
// CNT single-port banks; rows colliding on a bank at different words are
// serialised over several passes, rows with identical addresses share a pass.
module dcache_tile_banked
  import cherry_dcache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 freeze,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [AW-1:0]        req_addr,
  input  logic [AW-1:0]        req_stride,
  input  logic [LINE*SZ-1:0]   req_dat_w,
  output logic                 rsp_valid,
  output logic                 rsp_we,
  output logic [LINE*SZ-1:0]   rsp_dat_r,
  output logic [PW-1:0]        rsp_passes
);

  function automatic logic [LOGCNT-1:0] bank_of(input logic [AW-1:0] a);
    return a[LOGCNT-1:0];
  endfunction

  function automatic logic [DEPTH_LOG-1:0] word_of(input logic [AW-1:0] a);
    return a[AW-1:LOGCNT];
  endfunction

  state_t               state;
  logic                 we_p0;
  logic [AW-1:0]        addr_p0;
  logic [AW-1:0]        stride_p0;
  logic [LINE*SZ-1:0]   dat_p0;
  logic [AW-1:0]        row_addr_p1 [SZ];
  logic [AW-1:0]        row_calc    [SZ];
  logic [SZ-1:0]        pending;
  logic [SZ-1:0]        sel;
  logic [SZ-1:0]        sel_p2;
  logic [PW-1:0]        pass_cnt;

  logic [CNT-1:0]       lead_vld;
  logic [DEPTH_LOG-1:0] lead_word [CNT];
  logic [LINE-1:0]      ram_wdata [CNT];
  logic [LINE-1:0]      ram_rdata [CNT];
  logic [CNT-1:0]       ram_en;
  logic [CNT-1:0]       ram_we;
  logic [LINE*SZ-1:0]   merge_dat;

  assign req_ready = (state == IDLE);

  // Row addresses: row-0 address plus successive strides, wrapping at 2^AW.
  always_comb begin
    row_calc[0] = addr_p0;
    for (int r = 1; r < SZ; r++) row_calc[r] = row_calc[r-1] + stride_p0;
  end

  // Per-bank priority encoder: lowest pending row leads each bank, every pending
  // row matching its bank leader's word rides along, highest such row supplies write data.
  always_comb begin
    for (int b = 0; b < CNT; b++) begin
      lead_vld[b]  = 1'b0;
      lead_word[b] = '0;
      ram_wdata[b] = '0;
      for (int r = 0; r < SZ; r++) begin
        if (!lead_vld[b] && pending[r] && bank_of(row_addr_p1[r]) == LOGCNT'(b)) begin
          lead_vld[b]  = 1'b1;
          lead_word[b] = word_of(row_addr_p1[r]);
        end
      end
    end
    for (int r = 0; r < SZ; r++)
      sel[r] = pending[r] && (lead_word[bank_of(row_addr_p1[r])] == word_of(row_addr_p1[r]));
    for (int r = 0; r < SZ; r++)
      if (sel[r]) ram_wdata[bank_of(row_addr_p1[r])] = dat_p0[LINE*r +: LINE];
  end

  // Bank strobes only during an unfrozen, non-reset issue pass.
  always_comb begin
    for (int b = 0; b < CNT; b++) begin
      ram_en[b] = (state == ISSUE) && lead_vld[b] && !freeze && !reset;
      ram_we[b] = ram_en[b] && we_p0;
    end
  end

  // Fold in read data for the rows issued on the previous pass.
  always_comb begin
    merge_dat = rsp_dat_r;
    for (int r = 0; r < SZ; r++)
      if (sel_p2[r]) merge_dat[LINE*r +: LINE] = ram_rdata[bank_of(row_addr_p1[r])];
  end

  for (genvar b = 0; b < CNT; b++) begin : g_bank
    dcache_bank_ram #(
      .ADDR_W (DEPTH_LOG),
      .DATA_W (LINE)
    ) u_ram (
      .clk   (clk),
      .en    (ram_en[b]),
      .we    (ram_we[b]),
      .addr  (lead_word[b]),
      .wdata (ram_wdata[b]),
      .rdata (ram_rdata[b])
    );
  end

  // Request capture (p0) and per-row address registration (p1); data path, no reset.
  always_ff @(posedge clk) begin
    if (!freeze) begin
      if (state == IDLE && req_valid) begin
        we_p0     <= req_we;
        addr_p0   <= req_addr;
        stride_p0 <= req_stride;
        dat_p0    <= req_dat_w;
      end
      if (state == ADDR) row_addr_p1 <= row_calc;
    end
  end

  // Control FSM: accept, address, issue passes until no row is pending, respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      sel_p2     <= '0;
      pass_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_we     <= 1'b0;
      rsp_dat_r  <= '0;
      rsp_passes <= '0;
    end else if (!freeze) begin
      rsp_valid <= 1'b0;
      rsp_dat_r <= merge_dat;
      sel_p2    <= '0;
      case (state)
        IDLE: begin
          if (req_valid) state <= ADDR;
        end
        ADDR: begin
          pending  <= '1;
          pass_cnt <= '0;
          state    <= ISSUE;
        end
        ISSUE: begin
          pending  <= pending & ~sel;
          pass_cnt <= pass_cnt + 1'b1;
          if (!we_p0) sel_p2 <= sel;
          if ((pending & ~sel) == '0) state <= DONE;
        end
        DONE: begin
          rsp_valid  <= 1'b1;
          rsp_we     <= we_p0;
          rsp_passes <= pass_cnt;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_tile_banked.sv
// Directed bench for the banked tile data cache.
module tb_dcache_tile_banked;
  import cherry_dcache_pkg::*;

  localparam int TW = LINE * SZ;
  typedef logic [TW-1:0]   tile_t;
  typedef logic [LINE-1:0] row_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          freeze;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_stride;
  tile_t         req_dat_w;
  logic          rsp_valid;
  logic          rsp_we;
  tile_t         rsp_dat_r;
  logic [PW-1:0] rsp_passes;

  int    n_checks = 0;
  int    n_pass   = 0;
  tile_t prev_rd;

  always #5 clk = ~clk;

  dcache_tile_banked dut (
    .clk        (clk),
    .reset      (reset),
    .freeze     (freeze),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_stride (req_stride),
    .req_dat_w  (req_dat_w),
    .rsp_valid  (rsp_valid),
    .rsp_we     (rsp_we),
    .rsp_dat_r  (rsp_dat_r),
    .rsp_passes (rsp_passes)
  );

  task automatic check(input string tag, input tile_t got, input tile_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic row_t rp(input int v);
    return {SZ{BITS'(v)}};
  endfunction

  function automatic tile_t tl(input int a, input int b, input int c, input int d);
    return {rp(d), rp(c), rp(b), rp(a)};
  endfunction

  // Issue one request from #1 after an edge, wait for rsp_valid, check the response.
  task automatic run_req(input string name, input logic we, input int addr, input int stride,
                         input tile_t wdat, input tile_t exp_rd, input int exp_passes,
                         input int frz_at, input int frz_len, input bit hold);
    int    k;
    bit    seen;
    tile_t exp_dat;
    check({name, " ready"}, tile_t'(req_ready), tile_t'(1));
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = AW'(addr);
    req_stride = AW'(stride);
    req_dat_w  = wdat;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (frz_len > 0 && k == frz_at) freeze = 1'b1;
      if (frz_len > 0 && k == frz_at + frz_len) freeze = 1'b0;
      if (rsp_valid) seen = 1'b1;
    end
    exp_dat = we ? prev_rd : exp_rd;
    if (!we) prev_rd = exp_rd;
    check({name, " latency"}, tile_t'(k), tile_t'(exp_passes + 2 + frz_len));
    check({name, " passes"}, tile_t'(rsp_passes), tile_t'(exp_passes));
    check({name, " rsp_we"}, tile_t'(rsp_we), tile_t'(we));
    check({name, " data"}, rsp_dat_r, exp_dat);
    if (hold) begin
      freeze = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check({name, " held under freeze"}, tile_t'(rsp_valid), tile_t'(1));
      freeze = 1'b0;
    end
    @(posedge clk); #1;
    check({name, " pulse end"}, tile_t'(rsp_valid), tile_t'(0));
  endtask

  initial begin
    int seen_cnt;
    reset      = 1'b1;
    freeze     = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_stride = '0;
    req_dat_w  = '0;
    prev_rd    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", tile_t'(req_ready), tile_t'(1));
    check("reset rsp_valid", tile_t'(rsp_valid), tile_t'(0));
    check("reset rsp_we", tile_t'(rsp_we), tile_t'(0));
    check("reset rsp_dat_r", rsp_dat_r, tile_t'(0));
    check("reset rsp_passes", tile_t'(rsp_passes), tile_t'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    run_req("wr s1", 1'b1, 0, 1, tl('h11, 'h22, 'h33, 'h44), '0, 1, 0, 0, 0);
    run_req("rd s1", 1'b0, 0, 1, '0, tl('h11, 'h22, 'h33, 'h44), 1, 0, 0, 0);
    run_req("wr s32", 1'b1, 5, 32, tl('h101, 'h102, 'h103, 'h104), '0, 4, 0, 0, 0);
    run_req("rd s32", 1'b0, 5, 32, '0, tl('h101, 'h102, 'h103, 'h104), 4, 0, 0, 0);
    run_req("wr s0", 1'b1, 7, 0, tl('h201, 'h202, 'h203, 'h204), '0, 1, 0, 0, 0);
    run_req("rd s0", 1'b0, 7, 0, '0, tl('h204, 'h204, 'h204, 'h204), 1, 0, 0, 0);
    run_req("wr wrap", 1'b1, (1 << AW) - 1, 1, tl('h301, 'h302, 'h303, 'h304), '0, 1, 0, 0, 0);
    run_req("rd wrap", 1'b0, (1 << AW) - 1, 1, '0, tl('h301, 'h302, 'h303, 'h304), 1, 0, 0, 0);
    run_req("rd after wrap", 1'b0, 0, 1, '0, tl('h302, 'h303, 'h304, 'h44), 1, 0, 0, 0);
    run_req("rd s32 freeze", 1'b0, 5, 32, '0, tl('h101, 'h102, 'h103, 'h104), 4, 2, 3, 0);
    run_req("rd hold", 1'b0, 0, 1, '0, tl('h302, 'h303, 'h304, 'h44), 1, 0, 0, 1);
    run_req("wr base8", 1'b1, 8, 1, tl('h401, 'h402, 'h403, 'h404), '0, 1, 0, 0, 0);

    // Stride-32 write aborted by reset after its first pass.
    check("abort ready", tile_t'(req_ready), tile_t'(1));
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = AW'(9);
    req_stride = AW'(32);
    req_dat_w  = tl('h501, 'h502, 'h503, 'h504);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort req_ready", tile_t'(req_ready), tile_t'(1));
    check("abort rsp_valid", tile_t'(rsp_valid), tile_t'(0));
    seen_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen_cnt++;
    end
    check("abort no response", tile_t'(seen_cnt), tile_t'(0));
    prev_rd = '0;

    run_req("rd after abort", 1'b0, 8, 1, '0, tl('h401, 'h501, 'h403, 'h404), 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
